// File: rtl/atm_pkg.sv
// rtl/atm_pkg.sv - shared state and operation codes for the ATM session controller
package atm_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    WAIT_PIN = 2'b01,
    MENU     = 2'b10,
    LOCKED   = 2'b11
  } atm_state_e;

  localparam logic [1:0] SEL_DEP  = 2'b00;
  localparam logic [1:0] SEL_WD   = 2'b01;
  localparam logic [1:0] SEL_ENQ  = 2'b10;
  localparam logic [1:0] SEL_EXIT = 2'b11;

endpackage

// File: rtl/atm_lock_timer.sv
// rtl/atm_lock_timer.sv - loadable down-counter that holds at zero and flags expiry
module atm_lock_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/atm_ctrl_p.sv
// rtl/atm_ctrl_p.sv - ATM session FSM with PIN retry/lockout and balance datapath
module atm_ctrl_p
  import atm_pkg::*;
#(
  parameter int PIN_W       = 4,
  parameter int AMT_W       = 8,
  parameter int MAX_TRIES   = 3,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               card_in,
  input  logic                               bal_load,
  input  logic [AMT_W-1:0]                   bal_in,
  input  logic [PIN_W-1:0]                   prefed,
  input  logic                               pin_valid,
  input  logic [PIN_W-1:0]                   pin,
  input  logic                               op_valid,
  input  logic [1:0]                         sel,
  input  logic [AMT_W-1:0]                   amt,
  output logic [AMT_W-1:0]                   balance,
  output logic                               pin_ok,
  output logic                               pin_err,
  output logic                               locked,
  output logic                               done,
  output logic                               wd_err,
  output logic                               ovf_err,
  output logic [$clog2(MAX_TRIES+1)-1:0]     tries
);

  localparam int TW  = $clog2(MAX_TRIES + 1);
  localparam int LCW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  atm_state_e     state_q;
  logic [AMT_W-1:0] bal_q;
  logic [TW-1:0]  tries_q;
  logic           pin_ok_q, pin_err_q, locked_q, done_q, wd_err_q, ovf_err_q;

  logic [AMT_W:0]   sum_d;
  logic [TW-1:0]    tries_d;
  logic             pin_bad, lock_load, lock_expired;

  assign sum_d     = {1'b0, bal_q} + {1'b0, amt};
  assign tries_d   = tries_q + 1'b1;
  assign pin_bad   = (state_q == WAIT_PIN) && pin_valid && (pin != prefed);
  // Timer is armed on the same edge that enters LOCKED.
  assign lock_load = pin_bad && (tries_d == TW'(MAX_TRIES));

  atm_lock_timer #(.W(LCW)) u_lock_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (lock_load),
    .load_val_i (LCW'(LOCK_CYCLES - 1)),
    .en_i       (state_q == LOCKED),
    .expired_o  (lock_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bal_q     <= '0;
      tries_q   <= '0;
      pin_ok_q  <= 1'b0;
      pin_err_q <= 1'b0;
      locked_q  <= 1'b0;
      done_q    <= 1'b0;
      wd_err_q  <= 1'b0;
      ovf_err_q <= 1'b0;
    end else begin
      pin_err_q <= 1'b0;
      done_q    <= 1'b0;
      wd_err_q  <= 1'b0;
      ovf_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bal_load) bal_q <= bal_in;
          if (card_in) state_q <= WAIT_PIN;
        end
        WAIT_PIN: begin
          if (pin_valid) begin
            if (pin == prefed) begin
              state_q  <= MENU;
              pin_ok_q <= 1'b1;
              tries_q  <= '0;
            end else begin
              tries_q   <= tries_d;
              pin_err_q <= 1'b1;
              if (lock_load) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
              end
            end
          end
        end
        MENU: begin
          if (op_valid) begin
            done_q <= 1'b1;
            case (sel)
              SEL_DEP: begin
                if (sum_d[AMT_W]) ovf_err_q <= 1'b1;
                else              bal_q     <= sum_d[AMT_W-1:0];
              end
              SEL_WD: begin
                if (amt > bal_q) wd_err_q <= 1'b1;
                else             bal_q    <= bal_q - amt;
              end
              SEL_ENQ: ;
              default: begin
                pin_ok_q <= 1'b0;
                tries_q  <= '0;
                state_q  <= IDLE;
              end
            endcase
          end
        end
        LOCKED: begin
          if (lock_expired) begin
            state_q  <= IDLE;
            locked_q <= 1'b0;
            tries_q  <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign balance = bal_q;
  assign pin_ok  = pin_ok_q;
  assign pin_err = pin_err_q;
  assign locked  = locked_q;
  assign done    = done_q;
  assign wd_err  = wd_err_q;
  assign ovf_err = ovf_err_q;
  assign tries   = tries_q;

endmodule

// File: tb/tb_atm_ctrl_p.sv
// tb/tb_atm_ctrl_p.sv - directed self-checking bench for atm_ctrl_p
module tb_atm_ctrl_p;

  logic       clk = 1'b0;
  logic       rst, card_in, bal_load, pin_valid, op_valid;
  logic [7:0] bal_in, amt, balance;
  logic [3:0] prefed, pin;
  logic [1:0] sel, tries;
  logic       pin_ok, pin_err, locked, done, wd_err, ovf_err;

  int n_cmp = 0;
  int n_bad = 0;
  int n_lock;
  bit lock_seen_end;

  always #5 clk = ~clk;

  atm_ctrl_p #(.PIN_W(4), .AMT_W(8), .MAX_TRIES(3), .LOCK_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .card_in(card_in), .bal_load(bal_load), .bal_in(bal_in),
    .prefed(prefed), .pin_valid(pin_valid), .pin(pin), .op_valid(op_valid),
    .sel(sel), .amt(amt), .balance(balance), .pin_ok(pin_ok), .pin_err(pin_err),
    .locked(locked), .done(done), .wd_err(wd_err), .ovf_err(ovf_err), .tries(tries)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [1:0] s, input logic [7:0] a);
    op_valid = 1'b1; sel = s; amt = a;
    step();
  endtask

  task automatic present_pin(input logic [3:0] p);
    pin_valid = 1'b1; pin = p;
    step();
  endtask

  initial begin
    rst = 1'b1; card_in = 0; bal_load = 0; bal_in = 0; pin_valid = 0; pin = 0;
    op_valid = 0; sel = 0; amt = 0; prefed = 4'hA;
    step(); step();
    rst = 1'b0;
    check("rst_balance", balance, 0);
    check("rst_pin_ok", pin_ok, 0);
    check("rst_locked", locked, 0);
    check("rst_tries", tries, 0);
    check("rst_done", done, 0);

    // load + card in the same cycle
    bal_load = 1; bal_in = 8'd100; card_in = 1;
    step();
    bal_load = 0; card_in = 0;
    check("load_balance", balance, 100);
    present_pin(4'hA);
    pin_valid = 0;
    check("pin_ok_set", pin_ok, 1);
    check("pin_ok_err", pin_err, 0);
    op(2'b00, 8'd50);
    check("dep50_done", done, 1);
    check("dep50_bal", balance, 150);

    // back-to-back withdraws
    op(2'b01, 8'd200);
    check("wd200_err", wd_err, 1);
    check("wd200_bal", balance, 150);
    check("wd200_done", done, 1);
    op(2'b01, 8'd150);
    check("wd150_err", wd_err, 0);
    check("wd150_bal", balance, 0);
    check("wd150_done", done, 1);
    op_valid = 0;
    step();
    check("done_pulse_end", done, 0);

    op(2'b00, 8'd250);
    check("dep250_bal", balance, 250);
    op(2'b00, 8'd10);
    check("ovf_err", ovf_err, 1);
    check("ovf_bal", balance, 250);
    op(2'b00, 8'd5);
    check("dep5_ovf", ovf_err, 0);
    check("dep5_bal", balance, 255);
    op(2'b00, 8'd0);
    check("dep0_done", done, 1);
    check("dep0_ovf", ovf_err, 0);
    check("dep0_bal", balance, 255);
    op(2'b10, 8'd77);
    check("enq_done", done, 1);
    check("enq_bal", balance, 255);
    op(2'b11, 8'd0);
    op_valid = 0;
    check("exit_done", done, 1);
    check("exit_pin_ok", pin_ok, 0);

    // three wrong PINs -> lockout
    card_in = 1; step(); card_in = 0;
    present_pin(4'h5);
    check("bad1_err", pin_err, 1);
    check("bad1_tries", tries, 1);
    present_pin(4'h5);
    check("bad2_err", pin_err, 1);
    check("bad2_tries", tries, 2);
    present_pin(4'h5);
    pin_valid = 0;
    check("bad3_err", pin_err, 1);
    check("bad3_tries", tries, 3);
    check("bad3_locked", locked, 1);
    card_in = 1;
    n_lock = 1;
    lock_seen_end = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (i == 2) card_in = 0;
      if (i == 0) check("lock_err_pulse", pin_err, 0);
      if (!locked) begin
        lock_seen_end = 1;
        break;
      end
      n_lock++;
    end
    check("lock_ended", lock_seen_end, 1);
    check("lock_len", n_lock, 16);
    check("lock_tries", tries, 0);
    // in IDLE: a PIN here must be ignored since card_in during lockout was dropped
    present_pin(4'hA);
    pin_valid = 0;
    check("idle_pin_ignored", pin_ok, 0);

    // two wrong then correct
    card_in = 1; step(); card_in = 0;
    present_pin(4'h3);
    present_pin(4'h3);
    check("retry_tries2", tries, 2);
    present_pin(4'hA);
    pin_valid = 0;
    check("retry_tries0", tries, 0);
    check("retry_pin_ok", pin_ok, 1);
    op(2'b11, 8'd0);
    op_valid = 0;
    check("exit2_pin_ok", pin_ok, 0);
    op(2'b00, 8'd1);
    op_valid = 0;
    check("idle_op_ignored", done, 0);
    check("idle_op_bal", balance, 255);

    // reset in MENU with a pending op
    card_in = 1; step(); card_in = 0;
    present_pin(4'hA);
    pin_valid = 0;
    check("pre_rst_pin_ok", pin_ok, 1);
    rst = 1; op_valid = 1; sel = 2'b01; amt = 8'd5;
    step();
    rst = 0;
    check("rst_mid_done", done, 0);
    check("rst_mid_bal", balance, 0);
    check("rst_mid_pin_ok", pin_ok, 0);
    step();
    op_valid = 0;
    check("rst_then_idle", done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/atm_ctrl_p.md
# atm_ctrl_p

Parametrised ATM session controller: PIN verification with an attempt counter and timed lockout, followed by a menu of deposit, withdraw, balance-enquiry and exit operations on a held balance register. It generalises the 4-bit single-shot PIN/deposit/withdraw block. Adds configurable widths, a real retry counter, lockout, and overflow and insufficient-funds checking. It sits between the keypad/card front end and the account-balance store.

## Interface
- PIN_W, 4: PIN width in bits
- AMT_W, 8: balance/amount width in bits
- MAX_TRIES, 3: wrong PINs per session before lockout (≥1)
- LOCK_CYCLES, 16: lockout duration in clk cycles (≥1)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- card_in  in  1  session-start pulse
- bal_load  in  1  load bal_in into balance (IDLE only)
- bal_in  in  AMT_W  balance load value
- prefed  in  PIN_W  stored account PIN
- pin_valid  in  1  pin is presented this cycle
- pin  in  PIN_W  user-entered PIN
- op_valid  in  1  operation request strobe
- sel  in  2  00 deposit, 01 withdraw, 10 enquiry, 11 exit
- amt  in  AMT_W  operation amount
- balance  out  AMT_W  current balance
- pin_ok  out  1  level: session authenticated
- pin_err  out  1  1-cycle pulse: wrong PIN
- locked  out  1  level: lockout active
- done  out  1  1-cycle pulse: operation completed (success or error)
- wd_err  out  1  1-cycle pulse: withdraw refused, amt > balance
- ovf_err  out  1  1-cycle pulse: deposit refused, sum exceeds 2^AMT_W−1
- tries  out  $clog2(MAX_TRIES+1)  wrong attempts this session

## Operation
- States: IDLE, WAIT_PIN, MENU, LOCKED.
- Reset: state IDLE; balance 0; tries 0; all flags and pulses 0; lock counter 0.
- IDLE:
  - bal_load=1 sets balance ← bal_in.
  - card_in=1 moves to WAIT_PIN. Both may occur in the same cycle; both take effect.
- WAIT_PIN, on pin_valid:
  - pin==prefed: go to MENU, pin_ok←1, tries←0.
  - Mismatch: tries+1 and pin_err pulse. If new tries==MAX_TRIES, go to LOCKED, locked←1, lock counter←LOCK_CYCLES−1. Otherwise stay.
- MENU, on op_valid, single-cycle execute plus done pulse:
  - Deposit: use an AMT_W+1-bit sum. If carry, ovf_err and balance unchanged; else balance+=amt.
  - Withdraw: if amt>balance, wd_err and balance unchanged; else balance−=amt. amt==balance is allowed and gives 0.
  - Enquiry: done only.
  - Exit: done, pin_ok←0, tries←0, go to IDLE.
- LOCKED: counter decrements each cycle. At 0, go to IDLE, locked←0, tries←0.
- Inputs outside their state are ignored:
  - pin_valid outside WAIT_PIN.
  - op_valid outside MENU.
  - bal_load outside IDLE.
  - card_in outside IDLE.
- amt=0 is legal: done, no change, no error.

## Timing
- All outputs registered. A response appears on the cycle after the sampling edge, so latency is 1.
- pin_err, done, wd_err and ovf_err are exactly one cycle wide, including under back-to-back strobes.
- Back-to-back op_valid every cycle in MENU gives one operation per cycle. Each operation sees the balance updated by the previous one.
- Lockout lasts exactly LOCK_CYCLES cycles with locked=1, then one cycle in IDLE before a new card_in is accepted.
- rst mid-session or mid-lockout returns to the reset state at the next edge and discards any pending strobe.

## Structure
- Shared package atm_pkg holds:
  - State enum (IDLE, WAIT_PIN, MENU, LOCKED).
  - sel codes SEL_DEP, SEL_WD, SEL_ENQ, SEL_EXIT.
- Sub-module atm_lock_timer is a parametrised down-counter with load/expire, instantiated once.
- FSM, balance datapath and attempt counter stay in atm_ctrl_p.

## Test plan
- Load bal 100, card, pin==prefed=4'hA, deposit 50 → pin_ok=1, balance=150, done pulse.
- Balance 150, withdraw 200 → wd_err pulse, balance stays 150. Then withdraw 150 → balance 0, no error.
- Balance 250 (AMT_W=8), deposit 10 → ovf_err, balance 250. Deposit 5 → balance 255.
- Three wrong PINs → pin_err ×3, tries 1,2,3, locked=1 for exactly 16 cycles, then IDLE with tries=0. card_in during lockout is ignored.
- Two wrong PINs then a correct one → tries returns to 0 and pin_ok=1. Exit → IDLE, pin_ok=0.
- rst asserted in MENU with op_valid high → no done, balance=0, state IDLE on the next cycle.
